// File: rtl/dft_selftest_seq_if.sv
// Handshake bundle between the self-test sequencer, the system test controller
// and the DFT core / output-checker pair.
interface dft_selftest_seq_if;
    logic       start;
    logic       abort;
    logic       dft_done;
    logic [7:0] outp;
    logic [2:0] k;
    logic       dft_start;
    logic       busy;
    logic       done;
    logic [7:0] pass_mask;
    logic       all_pass;
    logic       timeout_err;
    logic [2:0] err_case;

    modport master (
        output start, abort, dft_done, outp,
        input  k, dft_start, busy, done, pass_mask, all_pass, timeout_err, err_case
    );

    modport slave (
        input  start, abort, dft_done, outp,
        output k, dft_start, busy, done, pass_mask, all_pass, timeout_err, err_case
    );
endinterface

// File: rtl/dft_selftest_seq.sv
// BIST sequencer: runs the DFT core once per test case, waits for completion
// with a timeout, samples the checker flag for that case and builds a pass mask.
module dft_selftest_seq #(
    parameter int NUM_CASES = 8,
    parameter int TIMEOUT   = 1023,
    parameter int SETTLE    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dft_selftest_seq_if.slave  bus
);
    localparam int         WAIT_W    = $clog2(TIMEOUT + 1);
    localparam int         SETL_W    = $clog2(SETTLE + 1);
    localparam logic [2:0] LAST_K    = 3'(NUM_CASES - 1);
    localparam logic [7:0] CASE_MASK = 8'((1 << NUM_CASES) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_SETTLE, S_CHECK, S_NEXT, S_FINISH
    } state_t;

    state_t              state, state_n;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SETL_W-1:0]   settle_cnt;
    logic [2:0]          k;
    logic [7:0]          pass_mask;
    logic                all_pass;
    logic                timeout_err;
    logic [2:0]          err_case;

    logic ld_run, ld_settle, hit_timeout, wr_pass, inc_k, set_all_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n      = state;
        ld_run       = 1'b0;
        ld_settle    = 1'b0;
        hit_timeout  = 1'b0;
        wr_pass      = 1'b0;
        inc_k        = 1'b0;
        set_all_pass = 1'b0;
        // Abort beats every other transition, including a completion in WAIT.
        if (bus.abort && state != S_IDLE) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ld_run  = 1'b1;
                        state_n = S_LAUNCH;
                    end
                end
                S_LAUNCH: state_n = S_WAIT;
                S_WAIT: begin
                    // dft_done on the final allowed cycle still counts as success.
                    if (bus.dft_done) begin
                        ld_settle = 1'b1;
                        state_n   = S_SETTLE;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        hit_timeout = 1'b1;
                        state_n     = S_FINISH;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state_n = S_CHECK;
                end
                S_CHECK: begin
                    wr_pass = 1'b1;
                    state_n = S_NEXT;
                end
                S_NEXT: begin
                    if (k == LAST_K) begin
                        set_all_pass = 1'b1;
                        state_n      = S_FINISH;
                    end else begin
                        inc_k   = 1'b1;
                        state_n = S_LAUNCH;
                    end
                end
                S_FINISH: state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            settle_cnt  <= '0;
            k           <= '0;
            pass_mask   <= '0;
            all_pass    <= 1'b0;
            timeout_err <= 1'b0;
            err_case    <= '0;
        end else begin
            if (state == S_LAUNCH)    wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

            if (ld_settle)                                settle_cnt <= SETL_W'(SETTLE - 1);
            else if (state == S_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

            if (ld_run) begin
                k           <= '0;
                pass_mask   <= '0;
                all_pass    <= 1'b0;
                timeout_err <= 1'b0;
                err_case    <= '0;
            end
            if (hit_timeout) begin
                timeout_err <= 1'b1;
                err_case    <= k;
                all_pass    <= 1'b0;
            end
            if (wr_pass) pass_mask[k] <= bus.outp[k];
            if (inc_k)   k <= k + 3'd1;
            // Registered on entry to FINISH so it is already valid alongside done.
            if (set_all_pass) all_pass <= (&(pass_mask | ~CASE_MASK)) & ~timeout_err;
        end
    end

    assign bus.dft_start   = (state == S_LAUNCH) && !bus.abort;
    assign bus.done        = (state == S_FINISH) && !bus.abort;
    assign bus.busy        = (state != S_IDLE);
    assign bus.k           = k;
    assign bus.pass_mask   = pass_mask;
    assign bus.all_pass    = all_pass;
    assign bus.timeout_err = timeout_err;
    assign bus.err_case    = err_case;
endmodule

// File: tb/tb_dft_selftest_seq.sv
// Bench for dft_selftest_seq: DFT/checker model, scoreboard of expected k per
// dft_start and expected results per done, driven from a table of runs.
module tb_dft_selftest_seq;
    localparam int N   = 8;
    localparam int TMO = 16;
    localparam int ST  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dft_selftest_seq_if bus();

    dft_selftest_seq #(.NUM_CASES(N), .TIMEOUT(TMO), .SETTLE(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] fail_mask;
        int         hang;
        int         dly;
        int         starts;
        int         spacing;
        int         gap;
        logic [7:0] pm;
        logic       ap;
        logic       to;
        logic [2:0] ec;
    } vec_t;

    typedef struct {
        logic [7:0] pm;
        logic       ap;
        logic       to;
        logic [2:0] ec;
        int         gap;
    } res_t;

    vec_t       tbl [7];
    logic [2:0] kq [$];
    res_t       rq [$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, last_start = -1, done_cnt = 0, dd_cnt = 0;
    int exp_spacing = 11;
    logic [7:0] fail_mask = 8'h00;
    int hang = 8;
    int dly  = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // DFT core / checker model plus output monitor, all on the falling edge.
    always @(negedge clk) begin : model
        logic [7:0] noise;
        res_t       r;
        cyc++;
        bus.dft_done = 1'b0;
        if (!rst_n) dd_cnt = 0;
        else if (dd_cnt > 0) begin
            dd_cnt--;
            if (dd_cnt == 0) bus.dft_done = 1'b1;
        end
        noise          = 8'($urandom);
        noise[bus.k]   = ~fail_mask[bus.k];
        if (bus.k == 3'd6) noise[5] = 1'b1;
        bus.outp       = noise;
        if (!bus.busy) last_start = -1;
        if (bus.dft_start) begin
            if (kq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_dft_start: got k=%0d, required no pulse (cycle %0d)", bus.k, cyc);
            end else begin
                check("dft_start_k", 32'(bus.k), 32'(kq.pop_front()));
            end
            if (last_start >= 0) check("start_spacing", 32'(cyc - last_start), 32'(exp_spacing));
            last_start = cyc;
            if (int'(bus.k) != hang) dd_cnt = dly + 1;
        end
        if (bus.done) begin
            done_cnt++;
            if (rq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no pulse (cycle %0d)", cyc);
            end else begin
                r = rq.pop_front();
                check("pass_mask",   32'(bus.pass_mask),   32'(r.pm));
                check("all_pass",    32'(bus.all_pass),    32'(r.ap));
                check("timeout_err", 32'(bus.timeout_err), 32'(r.to));
                check("err_case",    32'(bus.err_case),    32'(r.ec));
                check("busy_in_finish", 32'(bus.busy), 32'd1);
                check("done_gap", 32'(cyc - last_start), 32'(r.gap));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_k"},           32'(bus.k),           32'd0);
        check({tag, "_dft_start"},   32'(bus.dft_start),   32'd0);
        check({tag, "_busy"},        32'(bus.busy),        32'd0);
        check({tag, "_done"},        32'(bus.done),        32'd0);
        check({tag, "_pass_mask"},   32'(bus.pass_mask),   32'd0);
        check({tag, "_all_pass"},    32'(bus.all_pass),    32'd0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
        check({tag, "_err_case"},    32'(bus.err_case),    32'd0);
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic setup(input vec_t v, input bit push_res);
        res_t r;
        fail_mask   = v.fail_mask;
        hang        = v.hang;
        dly         = v.dly;
        exp_spacing = v.spacing;
        for (int c = 0; c < v.starts; c++) kq.push_back(3'(c));
        r.pm = v.pm; r.ap = v.ap; r.to = v.to; r.ec = v.ec; r.gap = v.gap;
        if (push_res) rq.push_back(r);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("launch_dft_start", 32'(bus.dft_start), 32'd1);
        check("launch_k", 32'(bus.k), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int d0 = done_cnt;
        setup(v, 1'b1);
        pulse_start();
        wait_done(d0, 400, name);
        tick();
        check("busy_after_finish", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        check("pending_starts", 32'(kq.size()), 32'd0);
    endtask

    // Runs to case 2, then interrupts in its first SETTLE cycle.
    task automatic run_to_settle_case2(output bit ok);
        int n = 0;
        setup(tbl[0], 1'b0);
        kq.delete();
        for (int c = 0; c < 3; c++) kq.push_back(3'(c));
        pulse_start();
        while (!(bus.k == 3'd2 && bus.dft_done) && n < 200) begin
            tick();
            n++;
        end
        ok = (n < 200);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL reach_case2_done: got no dft_done in case 2 within 200 cycles, required one");
        end
        tick();
    endtask

    initial begin
        int  d0;
        logic [2:0] k_before;
        bit  ok;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        //            fail   hang dly starts spc gap  pm     ap    to    ec
        tbl[0] = '{8'h00, 8,   5,  8,     11, 11, 8'hFF, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{8'h40, 8,   5,  8,     11, 11, 8'hBF, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{8'h00, 3,   5,  4,     11, 17, 8'h07, 1'b0, 1'b1, 3'd3};
        tbl[3] = '{8'h00, 8,   15, 8,     21, 21, 8'hFF, 1'b1, 1'b0, 3'd0};
        tbl[4] = '{8'h81, 8,   0,  8,     6,  6,  8'h7E, 1'b0, 1'b0, 3'd0};
        tbl[5] = '{8'h02, 7,   5,  8,     11, 17, 8'h7D, 1'b0, 1'b1, 3'd7};
        tbl[6] = '{8'h00, 8,   16, 1,     11, 17, 8'h00, 1'b0, 1'b1, 3'd0};

        #1 rst_n = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("run%0d_done", i));

        // start while busy must neither restart nor move k
        d0 = done_cnt;
        setup(tbl[0], 1'b1);
        pulse_start();
        repeat (20) tick();
        k_before  = bus.k;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_start_k", 32'(bus.k), 32'(k_before));
        check("busy_start_busy", 32'(bus.busy), 32'd1);
        wait_done(d0, 400, "busy_start_done");
        repeat (4) tick();

        // abort in SETTLE of case 2
        d0 = done_cnt;
        run_to_settle_case2(ok);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_pass_mask", 32'(bus.pass_mask), 32'h03);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (30) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_pending", 32'(kq.size()), 32'd0);
        run_vec(tbl[0], "after_abort_done");

        // asynchronous reset at the same point
        d0 = done_cnt;
        run_to_settle_case2(ok);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);
        check("reset_pending", 32'(kq.size()), 32'd0);
        run_vec(tbl[0], "after_reset_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dft_selftest_seq.md
# dft_selftest_seq

Built-in self-test sequencer for the 16-point floating-point DFT core. It steps the test-case index `k` through cases 0..NUM_CASES-1, starts the DFT core once per case and waits for completion with a timeout. It then samples the matching pass flag from the output checker and accumulates a per-case pass mask. It sits between the system-level test controller and the DFT core/output-checker pair. It owns `k` and `dft_start` exclusively.

## Interface
- NUM_CASES, 8, number of test cases run, legal 1..8
- TIMEOUT, 1023, maximum cycles spent in WAIT for `dft_done`, legal ≥ 1
- SETTLE, 2, cycles between `dft_done` and sampling the checker, legal ≥ 1

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a self-test run; sampled only in IDLE
- abort  in  1  synchronous abort to IDLE, no `done` pulse
- dft_done  in  1  DFT core finished current case; only used in WAIT
- outp  in  8  checker pass flags; bit k valid for case k
- k  out  3  current test-case index to the DFT core and checker
- dft_start  out  1  one-cycle start pulse to the DFT core
- busy  out  1  high from the cycle after `start` until FINISH completes
- done  out  1  one-cycle pulse at end of run
- pass_mask  out  8  bit i = case i passed; bits ≥ NUM_CASES always 0
- all_pass  out  1  valid with `done`; held until next `start`
- timeout_err  out  1  sticky until next `start`
- err_case  out  3  `k` value at timeout; 0 if no timeout

## Operation
- Reset: all outputs 0. The FSM enters IDLE. Wait and settle counters are cleared.
- FSM states: IDLE, LAUNCH, WAIT, SETTLE, CHECK, NEXT, FINISH.
- IDLE
  - If `start`=1: clear `pass_mask`, `all_pass`, `timeout_err` and `err_case`; set `k`=0 and `busy`=1; go to LAUNCH.
- LAUNCH
  - Drive `dft_start`=1 for this cycle only and clear the wait counter.
  - Go to WAIT.
- WAIT
  - Increment the wait counter each cycle.
  - If `dft_done`=1, load the settle counter and go to SETTLE.
  - Otherwise, if the counter reaches TIMEOUT, set `timeout_err`=1 and `err_case`=`k`. `pass_mask[k]` stays 0. Go to FINISH; the run aborts.
  - If `dft_done` and the timeout occur in the same cycle, `dft_done` wins.
- SETTLE
  - Count down SETTLE cycles, then go to CHECK.
- CHECK
  - Set `pass_mask[k]` = `outp[k]`. All other `outp` bits are ignored.
  - Go to NEXT.
- NEXT
  - If `k` = NUM_CASES-1, go to FINISH.
  - Otherwise, increment `k` and go to LAUNCH.
- FINISH
  - Pulse `done`=1 and register `all_pass` = (`pass_mask[NUM_CASES-1:0]` all ones) & !`timeout_err`.
  - `busy` is 0 from the next cycle. Go to IDLE.
- `k` changes only on `start` in IDLE and in NEXT. It is stable from LAUNCH through CHECK of each case.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state:
  - Next state is IDLE and `busy`=0.
  - No `done` pulse is issued; `dft_start` is not driven.
  - `pass_mask` keeps its partial contents.
  - `abort` has priority over every other transition.
- `dft_done` outside WAIT is ignored, including a stale `done` arriving after a timeout.
- The wait counter is wide enough to hold TIMEOUT without wrap (clog2(TIMEOUT+1) bits).
- Asynchronous reset mid-run immediately returns all outputs to reset values. No `done` pulse is issued.

## Timing
- `start` high at edge 0. `busy` and state LAUNCH are registered at edge 0, so `dft_start` is high in cycle 1.
- WAIT begins in cycle 2. If `dft_done` is sampled high in WAIT cycle t:
  - SETTLE occupies cycles t+1..t+SETTLE.
  - CHECK is in cycle t+SETTLE+1.
  - NEXT is in cycle t+SETTLE+2.
  - The next LAUNCH is in cycle t+SETTLE+3.
- Per-case overhead beyond DFT latency: SETTLE+4 cycles.
- `done` is high exactly one cycle, in FINISH. `pass_mask` and `all_pass` are valid in that cycle.
- Timeout: with no `dft_done`, FINISH follows the TIMEOUT-th WAIT cycle.

## Test plan
- All pass: model the DFT with done 5 cycles after `dft_start`, and `outp[k]`=1 for every case. Require:
  - eight `dft_start` pulses with `k`=0..7;
  - `done` once, with `pass_mask`=8'hFF and `all_pass`=1;
  - spacing between `dft_start` pulses = 5+SETTLE+4 = 11 cycles.
- Single fail: `outp[6]`=0 during case 6, and `outp[5]`=1 held through case 6. Require `pass_mask`=8'hBF, `all_pass`=0 and `timeout_err`=0.
- Timeout: the DFT never asserts done on case 3, with TIMEOUT=16. Require:
  - `timeout_err`=1, `err_case`=3, `pass_mask`=8'h07;
  - `done` 16 cycles after WAIT entry;
  - no `dft_start` for case 4.
- Boundary: `dft_done` asserted in the exact cycle the counter hits TIMEOUT. Require case acceptance (`timeout_err`=0). Also, `start` pulses while `busy` produce no restart and no change to `k`.
- Abort/reset: assert `abort` in SETTLE of case 2. Require IDLE next cycle, `busy`=0, no `done`, `pass_mask`=8'h03.
  - Repeat the same point with `rst_n` low instead of `abort`. Require all outputs 0 asynchronously.
  - A fresh `start` after either must run all 8 cases normally.
